// File: rtl/ram_single_port_if.sv
// rtl/ram_single_port_if.sv - bus bundle between a RAM client and ram_single_port
interface ram_single_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr;
  logic [DATA_WIDTH-1:0] data_out;

  // Client side: drives address, data and the read/write select
  modport master (
    output address,
    output data_in,
    output wr,
    input  data_out
  );

  // RAM side: consumes the request, returns registered read data
  modport slave (
    input  address,
    input  data_in,
    input  wr,
    output data_out
  );

endinterface

// File: rtl/ram_single_port.sv
// rtl/ram_single_port.sv - 256x8 single-port synchronous RAM, write-through, sync clear
module ram_single_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_single_port_if.slave      bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  we_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;

  // Decode the cycle: a write stores data_in and echoes it, a read fetches the addressed word
  always_comb begin
    we_d       = bus.wr;
    waddr_d    = bus.address;
    wdata_d    = bus.data_in;
    data_out_d = mem_q[bus.address];
    if (bus.wr) begin
      data_out_d = bus.data_in;
    end
  end

  // Storage array: reset wipes every word and takes priority over a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_d) begin
      mem_q[waddr_d] <= wdata_d;
    end
  end

  // Output register: holds between edges, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_ram_single_port.sv
// tb/tb_ram_single_port.sv - directed self-checking bench for ram_single_port
module tb_ram_single_port;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ram_single_port_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_single_port #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Present one cycle at the falling edge, then settle just after the rising edge
  task automatic cycle(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rst         = r;
    bus.wr      = w;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.address = 8'h00;
    bus.data_in = 8'h00;

    // Test 1: reset for two cycles, then basic writes
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h44, 8'h99);
    check_val("reset_dout", bus.data_out, 8'h00);
    cycle(1'b0, 1'b1, 8'h00, 8'h00);
    check_val("wr_a0", bus.data_out, 8'h00);
    cycle(1'b0, 1'b1, 8'h01, 8'h01);
    check_val("wr_a1", bus.data_out, 8'h01);
    cycle(1'b0, 1'b1, 8'h03, 8'h03);
    check_val("wr_a3", bus.data_out, 8'h03);

    // Test 2: readback, plus an unwritten word and the word written during reset
    cycle(1'b0, 1'b0, 8'h00, 8'hFF);
    check_val("rd_a0", bus.data_out, 8'h00);
    cycle(1'b0, 1'b0, 8'h01, 8'hFF);
    check_val("rd_a1", bus.data_out, 8'h01);
    cycle(1'b0, 1'b0, 8'h03, 8'hFF);
    check_val("rd_a3", bus.data_out, 8'h03);
    cycle(1'b0, 1'b0, 8'h02, 8'hFF);
    check_val("rd_a2_unwritten", bus.data_out, 8'h00);
    cycle(1'b0, 1'b0, 8'h44, 8'hFF);
    check_val("rd_a44_reset_wr", bus.data_out, 8'h00);

    // Test 3: boundary addresses, no aliasing
    cycle(1'b0, 1'b1, 8'hFF, 8'hA5);
    check_val("wr_a255", bus.data_out, 8'hA5);
    cycle(1'b0, 1'b1, 8'h00, 8'h5A);
    check_val("wr_a0_5a", bus.data_out, 8'h5A);
    cycle(1'b0, 1'b0, 8'hFF, 8'h00);
    check_val("rd_a255", bus.data_out, 8'hA5);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    check_val("rd_a0_5a", bus.data_out, 8'h5A);
    cycle(1'b0, 1'b0, 8'h7F, 8'h00);
    check_val("rd_a127", bus.data_out, 8'h00);

    // Test 4: overwrite then read-after-write
    cycle(1'b0, 1'b1, 8'h07, 8'h11);
    check_val("wr_a7_11", bus.data_out, 8'h11);
    cycle(1'b0, 1'b1, 8'h07, 8'hEE);
    check_val("wr_a7_ee", bus.data_out, 8'hEE);
    cycle(1'b0, 1'b0, 8'h07, 8'h00);
    check_val("rd_a7", bus.data_out, 8'hEE);
    cycle(1'b0, 1'b0, 8'h01, 8'h00);
    check_val("rd_a1_kept", bus.data_out, 8'h01);

    // Test 6: hold behaviour (contents still intact before the mid-run reset)
    cycle(1'b0, 1'b0, 8'h03, 8'h00);
    check_val("hold_edge", bus.data_out, 8'h03);
    #1;
    bus.address = 8'h01;
    #1;
    check_val("hold_addr_chg", bus.data_out, 8'h03);
    bus.address = 8'hFF;
    @(negedge clk);
    check_val("hold_negedge", bus.data_out, 8'h03);

    // Test 5: reset mid-operation discards prior contents and a same-cycle write
    cycle(1'b0, 1'b1, 8'h09, 8'h3C);
    check_val("wr_a9", bus.data_out, 8'h3C);
    cycle(1'b1, 1'b1, 8'h0A, 8'hFF);
    check_val("midrst_dout", bus.data_out, 8'h00);
    cycle(1'b0, 1'b0, 8'h09, 8'h00);
    check_val("rd_a9_cleared", bus.data_out, 8'h00);
    cycle(1'b0, 1'b0, 8'h0A, 8'h00);
    check_val("rd_a10_discarded", bus.data_out, 8'h00);
    cycle(1'b0, 1'b0, 8'h07, 8'h00);
    check_val("rd_a7_cleared", bus.data_out, 8'h00);
    cycle(1'b0, 1'b0, 8'hFF, 8'h00);
    check_val("rd_a255_cleared", bus.data_out, 8'h00);

    // Back-to-back writes to distinct addresses all retained after reset
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h20 + i), 8'(8'hC0 + i));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 8'(8'h20 + i), 8'h00);
      check_val("b2b_rd", bus.data_out, 8'(8'hC0 + i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_single_port.md
# ram_single_port

Single-port synchronous RAM, 256 words × 8 bits, with one shared address bus for reads and writes. It serves as general-purpose scratch storage inside a single clock domain. A write or a registered read completes on every rising clock edge. A synchronous reset clears the whole array and the output register.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each word and of `data_in`/`data_out`.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH (256).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- address  input  ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- wr  input  1  1 = write cycle, 0 = read cycle.
- data_out  output  DATA_WIDTH  registered read data.

One clock; reset is synchronous and active-high.

## Operation
- Storage is `mem[0 .. 2**ADDR_WIDTH-1]`, each word DATA_WIDTH bits wide.
- Reset (`rst=1` at a rising edge):
  - Every memory word becomes 0.
  - `data_out` becomes 0.
  - `wr`, `address` and `data_in` are ignored in that cycle, so reset overrides a write.
- Write (`rst=0`, `wr=1`):
  - `mem[address] <= data_in`.
  - `data_out <= data_in` (write-through: the output shows the value just written).
- Read (`rst=0`, `wr=0`):
  - `data_out <= mem[address]`.
  - Memory is unchanged.
- There is no enable input. Every non-reset edge performs either a read or a write.
- Addressing:
  - All 2**ADDR_WIDTH addresses are valid.
  - No out-of-range condition exists.
  - There is no wrap or auto-increment; the address is used exactly as given.
- `data_out` holds its value between clock edges and changes only on a rising edge.
- X or Z on `wr` is not supported. The bench drives only 0 or 1.

## Timing
- All inputs are sampled at the rising edge of `clk`.
- Write latency: the new word is readable from the next edge. A read issued one cycle after a write to the same address returns the new data.
- Read latency: 1 cycle. `data_out` reflects `mem[address]` sampled at edge N, valid after edge N until edge N+1.
- Write-to-output: `data_out` equals `data_in` after the write edge.
- Back-to-back writes to different addresses on consecutive edges are all retained.
- Reset:
  - Takes effect at the first rising edge with `rst=1`.
  - After that edge, `data_out=0` and every address reads 0.
  - Deasserting `rst` allows normal operation from the next edge.
- Reset mid-sequence: contents written before the reset edge are lost. A write presented in the same cycle as `rst=1` is discarded.
- Power-up contents before the first reset are undefined. The bench applies reset first.

## Test plan
1. Reset then basic writes:
   - Stimulus: `rst` for 2 cycles, then write addr0=0x00, addr1=0x01, addr3=0x03.
   - Response: `data_out` shows 0x00, 0x01, 0x03 after each write edge.
2. Readback:
   - Stimulus: after test 1, read addr0, addr1, addr3 with `wr=0`.
   - Response: `data_out` = 0x00, 0x01, 0x03, each one cycle after its address is applied.
   - Then read addr2 (never written) → `data_out` = 0x00.
3. Boundary addresses:
   - Stimulus: write addr255=0xA5 and addr0=0x5A, then read both.
   - Response: 0xA5 and 0x5A respectively; no aliasing.
4. Overwrite and read-after-write:
   - Stimulus: write addr7=0x11, then write addr7=0xEE on the next edge, then read addr7 on the next edge.
   - Response: `data_out` = 0xEE.
5. Reset mid-operation:
   - Stimulus: write addr9=0x3C; assert `rst` together with `wr=1`, addr10=0xFF; release `rst`; read addr9 and addr10.
   - Response: `data_out` = 0x00 after the reset edge, then 0x00 for both reads.
6. Hold behaviour:
   - Stimulus: read addr3 (0x03), then change `address` between clock edges.
   - Response: `data_out` stays 0x03 until the next rising edge.
